serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 96 +++++++++
 tb/tb_serial_adder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used as the serial adder's per-cycle arithmetic slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder bit per cycle, LSB first; sum/carry_out are
// registered at completion and hold until the next result loads.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_nxt;

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign res_nxt = WIDTH'({fa_s, res_q} >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            a_q     <= a;
            b_q     <= b;
            carry_q <= carry_in;
            cnt     <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_co;
          res_q   <= res_nxt;
          cnt     <= cnt + CNT_W'(1);
          // Final bit: publish the completed result on the same edge as DONE.
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            sum       <= res_nxt;
            carry_out <= fa_co;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed WIDTH=8 scenarios plus random WIDTH=1 and
// WIDTH=32 regressions, with results checked by per-instance scoreboards.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // WIDTH=8 instance
  logic       rst8, start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  // WIDTH=1 instance
  logic       rst1, start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
  // WIDTH=32 instance
  logic        rst32, start32, cin32, busy32, done32, cout32;
  logic [31:0] a32, b32, sum32;

  logic [8:0]  q8[$];
  logic [1:0]  q1[$];
  logic [32:0] q32[$];
  logic [8:0]  pend8;
  logic [8:0]  last8;

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst8), .start(start8), .a(a8), .b(b8), .carry_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
  );

  serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst1), .start(start1), .a(a1), .b(b1), .carry_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1)
  );

  serial_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst32), .start(start32), .a(a32), .b(b32), .carry_in(cin32),
    .busy(busy32), .done(done32), .sum(sum32), .carry_out(cout32)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected_done(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=done_pulse required=no_pending_operation", name);
  endtask

  // Scoreboard monitors: pop the oldest expected result whenever done is seen.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) unexpected_done("w8_result");
      else chkv("w8_result", 65'({cout8, sum8}), 65'(q8.pop_front()));
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) unexpected_done("w1_result");
      else chkv("w1_result", 65'({cout1, sum1}), 65'(q1.pop_front()));
    end
    if (done32 === 1'b1) begin
      if (q32.size() == 0) unexpected_done("w32_result");
      else chkv("w32_result", 65'({cout32, sum32}), 65'(q32.pop_front()));
    end
  end

  task automatic launch8(input logic [7:0] ai, input logic [7:0] bi, input logic ci, input bit push);
    a8     = ai;
    b8     = bi;
    cin8   = ci;
    start8 = 1'b1;
    pend8  = {1'b0, ai} + {1'b0, bi} + {8'd0, ci};
    if (push) q8.push_back(pend8);
  endtask

  // Follows one WIDTH=8 operation from its accepting edge through the DONE cycle.
  task automatic shift8(input int poke_at, input bit hold);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0 && !hold) start8 = 1'b0;
      chk1("w8_busy", busy8, 1'b1);
      chk1("w8_done_early", done8, 1'b0);
      chkv("w8_sum_hold", 65'({cout8, sum8}), 65'(last8));
      if (poke_at >= 0 && i == poke_at) begin
        start8 = 1'b1;
        a8     = ~a8;
        b8     = b8 ^ 8'h5A;
        cin8   = ~cin8;
      end else if (poke_at >= 0 && i == poke_at + 1) begin
        start8 = 1'b0;
      end
    end
    @(negedge clk);
    chk1("w8_done", done8, 1'b1);
    chk1("w8_busy_at_done", busy8, 1'b0);
    last8 = pend8;
  endtask

  task automatic directed8();
    rst8 = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; last8 = '0;
    repeat (2) @(negedge clk);
    chk1("w8_reset_busy", busy8, 1'b0);
    chk1("w8_reset_done", done8, 1'b0);
    chkv("w8_reset_result", 65'({cout8, sum8}), 65'(0));

    // Start on the very first edge with reset released.
    rst8 = 1'b1;
    launch8(8'h35, 8'h4A, 1'b0, 1'b1);
    shift8(-1, 1'b0);
    @(negedge clk);
    chk1("w8_done_one_cycle", done8, 1'b0);
    chk1("w8_idle_after_done", busy8, 1'b0);

    launch8(8'hFF, 8'h00, 1'b1, 1'b1);
    shift8(-1, 1'b0);
    @(negedge clk);

    // A start three cycles in must be ignored.
    launch8(8'h12, 8'h34, 1'b1, 1'b1);
    shift8(2, 1'b0);
    @(negedge clk);

    // Start held through DONE chains straight into the next operation.
    launch8(8'h80, 8'h80, 1'b0, 1'b1);
    shift8(-1, 1'b1);
    launch8(8'h01, 8'h02, 1'b1, 1'b1);
    shift8(-1, 1'b0);
    @(negedge clk);
    chk1("w8_idle_after_chain", busy8, 1'b0);

    // Reset asserted in the fifth SHIFT cycle aborts the operation.
    launch8(8'h11, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) start8 = 1'b0;
    end
    rst8 = 1'b0;
    @(negedge clk);
    chk1("w8_abort_busy", busy8, 1'b0);
    chk1("w8_abort_done", done8, 1'b0);
    chkv("w8_abort_result", 65'({cout8, sum8}), 65'(0));
    rst8  = 1'b1;
    last8 = '0;
    repeat (12) begin
      @(negedge clk);
      chk1("w8_no_done_after_abort", done8, 1'b0);
    end

    // Reset wins over start on the same edge.
    a8 = 8'h0F; b8 = 8'hF0; start8 = 1'b1; rst8 = 1'b0;
    @(negedge clk);
    chk1("w8_reset_beats_start", busy8, 1'b0);
    rst8 = 1'b1; start8 = 1'b0;
    @(negedge clk);
    chk1("w8_stays_idle", busy8, 1'b0);
  endtask

  task automatic random1();
    rst1 = 1'b0; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    chkv("w1_reset_result", 65'({busy1, done1, cout1, sum1}), 65'(0));
    rst1 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom); start1 = 1'b1;
      q1.push_back({1'b0, a1} + {1'b0, b1} + {1'b0, cin1});
      @(negedge clk);
      chk1("w1_busy", busy1, 1'b1);
      start1 = 1'b0;
      for (int t = 0; done1 !== 1'b1; t++) begin
        if (t > 4) begin
          $display("FAIL w1_timeout actual=no_done required=done_within_2_cycles");
          failures++;
          $fatal(1, "w1 timeout");
        end
        start1 = ($urandom_range(3) == 0);
        a1 = 1'($urandom); b1 = 1'($urandom);
        @(negedge clk);
      end
      start1 = 1'b0;
      if ($urandom_range(1) == 1) repeat ($urandom_range(2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic random32();
    rst32 = 1'b0; start32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
    repeat (3) @(negedge clk);
    chkv("w32_reset_result", 65'({busy32, done32, cout32, sum32}), 65'(0));
    rst32 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); start32 = 1'b1;
      if (n < 4) begin
        a32 = 32'hFFFF_FFFF;
        b32 = (n[0]) ? 32'hFFFF_FFFF : 32'h0;
        cin32 = n[1];
      end
      q32.push_back(33'(a32) + 33'(b32) + 33'(cin32));
      @(negedge clk);
      chk1("w32_busy", busy32, 1'b1);
      start32 = 1'b0;
      for (int t = 0; done32 !== 1'b1; t++) begin
        if (t > 40) begin
          $display("FAIL w32_timeout actual=no_done required=done_within_33_cycles");
          failures++;
          $fatal(1, "w32 timeout");
        end
        start32 = ($urandom_range(7) == 0);
        a32 = $urandom; b32 = $urandom;
        @(negedge clk);
      end
      start32 = 1'b0;
      if ($urandom_range(1) == 1) repeat ($urandom_range(2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      directed8();
      random1();
      random32();
    join
    chkv("w8_queue_drained", 65'(q8.size()), 65'(0));
    chkv("w1_queue_drained", 65'(q1.size()), 65'(0));
    chkv("w32_queue_drained", 65'(q32.size()), 65'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
